// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded fields into 32-bit words for instruction RAM.
// Option macro INSTR_ENCODER_HALT_APPEND_EN appends a halt word on finish.
module instr_encoder #(
  parameter int N     = 32,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    fmt,
  input  logic [2:0]    op,
  input  logic [1:0]    func,
  input  logic [4:0]    rw,
  input  logic [4:0]    ra,
  input  logic [4:0]    rb,
  input  logic [N-1:0]  imm,
  input  logic          finish,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wd,
  output logic [AW:0]   count,
  output logic          full,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FULL,
    S_HALT,
    S_DONE
  } state_t;

`ifdef INSTR_ENCODER_HALT_APPEND_EN
  localparam int     CAP_I = DEPTH - 1;
  localparam state_t S_FIN = S_HALT;
`else
  localparam int     CAP_I = DEPTH;
  localparam state_t S_FIN = S_DONE;
`endif

  localparam logic [AW:0]  CAP    = (AW+1)'(CAP_I);
  localparam logic [AW:0]  ONE    = (AW+1)'(1);
  localparam logic [N-1:0] HALT_W = {3'b111, {(N-3){1'b0}}};

  state_t       state;
  state_t       state_n;
  logic [N-1:0] word;
  logic         bad;
  logic         is_r;
  logic         is_i;
  logic         is_ri;
  logic         xfer;
  logic         wr_user;
  logic         halt_wr;
  logic [AW:0]  count_inc;

  assign is_r      = (fmt == 2'b00);
  assign is_i      = (fmt == 2'b01);
  assign is_ri     = (fmt == 2'b10);
  assign xfer      = in_valid && in_ready;
  assign wr_user   = xfer && !bad && !clear;
  assign count_inc = count + ONE;

`ifdef INSTR_ENCODER_HALT_APPEND_EN
  assign halt_wr = (state == S_HALT);
`else
  assign halt_wr = 1'b0;
`endif

  // Field packing and range check of the immediate
  always_comb begin
    word = '0;
    bad  = 1'b0;
    unique case (1'b1)
      is_r: begin
        word[31:29] = op;
        word[28:24] = rw;
        word[23:19] = ra;
        word[18:14] = rb;
        word[1:0]   = func;
      end
      is_i: begin
        word[31:29] = op;
        word[28:0]  = imm[28:0];
        bad         = |imm[N-1:29];
      end
      is_ri: begin
        word[31:29] = op;
        word[28:24] = rw;
        word[23:19] = ra;
        word[18:0]  = imm[18:0];
        bad         = |imm[N-1:19];
      end
      default: bad = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RUN;
    else        state <= state_n;
  end

  // Next-state logic; clear overrides finish and transfers
  always_comb begin
    state_n = state;
    if (clear) begin
      state_n = S_RUN;
    end else begin
      unique case (state)
        S_RUN: begin
          if (finish)
            state_n = S_FIN;
          else if (wr_user && count_inc == CAP)
            state_n = S_FULL;
        end
        S_FULL: if (finish) state_n = S_FIN;
        S_HALT: state_n = S_DONE;
        S_DONE: state_n = S_DONE;
        default: state_n = S_RUN;
      endcase
    end
  end

  // State-decoded outputs; ready is held low during reset
  always_comb begin
    in_ready = reset && (state == S_RUN);
    done     = (state == S_DONE);
    full     = (count >= CAP);
  end

  // Registered write port, word counter and sticky reject flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      count    <= '0;
      err      <= 1'b0;
    end else if (clear) begin
      mem_we <= 1'b0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      mem_we <= wr_user || halt_wr;
      if (wr_user) begin
        mem_addr <= count[AW-1:0];
        mem_wd   <= word;
        count    <= count_inc;
      end else if (halt_wr) begin
        mem_addr <= count[AW-1:0];
        mem_wd   <= HALT_W;
        count    <= count_inc;
      end
      if (xfer && bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector table plus hand-written corner sequences.
// Expectations follow INSTR_ENCODER_HALT_APPEND_EN when it is defined.
module tb_instr_encoder;
  localparam int N     = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
`ifdef INSTR_ENCODER_HALT_APPEND_EN
  localparam int CAP = DEPTH - 1;
`else
  localparam int CAP = DEPTH;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          finish = 1'b0;
  logic [1:0]    fmt = 2'b00;
  logic [2:0]    op = 3'd0;
  logic [1:0]    func = 2'd0;
  logic [4:0]    rw = 5'd0;
  logic [4:0]    ra = 5'd0;
  logic [4:0]    rb = 5'd0;
  logic [N-1:0]  imm = '0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wd;
  logic [AW:0]   count;
  logic          full;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;

  instr_encoder #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .op(op), .func(func),
    .rw(rw), .ra(ra), .rb(rb), .imm(imm),
    .finish(finish), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd),
    .count(count), .full(full),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [2:0]  op;
    logic [1:0]  func;
    logic [4:0]  rw;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] imm;
    logic        we;
    logic [31:0] wd;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input vec_t v);
    fmt  = v.fmt;
    op   = v.op;
    func = v.func;
    rw   = v.rw;
    ra   = v.ra;
    rb   = v.rb;
    imm  = v.imm;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    tbl[0] = '{2'b00, 3'd2, 2'd1, 5'd3,  5'd1,  5'd2,  32'h0,        1'b1, 32'h43088001};
    tbl[1] = '{2'b01, 3'd1, 2'd0, 5'd0,  5'd0,  5'd0,  32'h1FFFFFFF, 1'b1, 32'h3FFFFFFF};
    tbl[2] = '{2'b01, 3'd1, 2'd0, 5'd0,  5'd0,  5'd0,  32'h20000000, 1'b0, 32'h0};
    tbl[3] = '{2'b10, 3'd4, 2'd0, 5'd5,  5'd6,  5'd0,  32'h0007FFFF, 1'b1, 32'h8537FFFF};
    tbl[4] = '{2'b10, 3'd4, 2'd0, 5'd5,  5'd6,  5'd0,  32'h00080000, 1'b0, 32'h0};
    tbl[5] = '{2'b11, 3'd1, 2'd0, 5'd1,  5'd1,  5'd1,  32'h0,        1'b0, 32'h0};
    tbl[6] = '{2'b00, 3'd7, 2'd3, 5'd31, 5'd31, 5'd31, 32'hFFFFFFFF, 1'b1, 32'hFFFFC003};
    tbl[7] = '{2'b01, 3'd0, 2'd0, 5'd0,  5'd0,  5'd0,  32'h0,        1'b1, 32'h00000000};
    tbl[8] = '{2'b10, 3'd3, 2'd0, 5'd0,  5'd31, 5'd0,  32'h00012345, 1'b1, 32'h60F92345};

    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we",    64'(mem_we),   64'd0);
    chk("rst_addr",  64'(mem_addr), 64'd0);
    chk("rst_wd",    64'(mem_wd),   64'd0);
    chk("rst_count", 64'(count),    64'd0);
    chk("rst_flags", 64'({full, done, err}), 64'd0);
    reset = 1'b1;
    step();
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      pulse_clear();
      set_fields(tbl[i]);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_we", i), 64'(mem_we), 64'(tbl[i].we));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].we));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(!tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_wd", i), 64'(mem_wd), 64'(tbl[i].wd));
        chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'd0);
      end
    end

    pulse_clear();
    for (int i = 0; i < CAP; i++) begin
      set_fields('{2'b00, 3'd1, 2'd0, 5'(i), 5'd0, 5'd0, 32'h0, 1'b1, 32'h0});
      in_valid = 1'b1;
      step();
      chk($sformatf("fill%0d_we", i), 64'(mem_we), 64'd1);
      chk($sformatf("fill%0d_addr", i), 64'(mem_addr), 64'(i));
      chk($sformatf("fill%0d_wd", i), 64'(mem_wd),
          64'(32'h20000000 | (32'(i) << 24)));
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ready", 64'(in_ready), 64'd0);
    step();
    in_valid = 1'b0;
    chk("full_ign_we", 64'(mem_we), 64'd0);
    chk("full_ign_count", 64'(count), 64'(CAP));
    finish = 1'b1;
    step();
    finish = 1'b0;
`ifdef INSTR_ENCODER_HALT_APPEND_EN
    chk("halt_gap_we", 64'(mem_we), 64'd0);
    chk("halt_gap_done", 64'(done), 64'd0);
    step();
    chk("halt_we", 64'(mem_we), 64'd1);
    chk("halt_addr", 64'(mem_addr), 64'd3);
    chk("halt_wd", 64'(mem_wd), 64'hE0000000);
`else
    chk("fin_we", 64'(mem_we), 64'd0);
`endif
    chk("fin_count", 64'(count), 64'd4);
    chk("fin_done", 64'(done), 64'd1);
    chk("fin_ready", 64'(in_ready), 64'd0);

    pulse_clear();
    set_fields(tbl[0]);
    in_valid = 1'b1;
    step();
    set_fields(tbl[1]);
    finish = 1'b1;
    step();
    in_valid = 1'b0;
    finish = 1'b0;
    chk("tf_we", 64'(mem_we), 64'd1);
    chk("tf_addr", 64'(mem_addr), 64'd1);
    chk("tf_wd", 64'(mem_wd), 64'h3FFFFFFF);
    chk("tf_count", 64'(count), 64'd2);
`ifdef INSTR_ENCODER_HALT_APPEND_EN
    chk("tf_done0", 64'(done), 64'd0);
    step();
    chk("tf_halt_we", 64'(mem_we), 64'd1);
    chk("tf_halt_addr", 64'(mem_addr), 64'd2);
    chk("tf_halt_wd", 64'(mem_wd), 64'hE0000000);
    chk("tf_halt_count", 64'(count), 64'd3);
    chk("tf_done", 64'(done), 64'd1);
`else
    chk("tf_done", 64'(done), 64'd1);
    step();
    chk("tf_idle_we", 64'(mem_we), 64'd0);
`endif
    pulse_clear();
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_ready", 64'(in_ready), 64'd1);

    set_fields(tbl[0]);
    in_valid = 1'b1;
    finish = 1'b1;
    clear = 1'b1;
    step();
    in_valid = 1'b0;
    finish = 1'b0;
    clear = 1'b0;
    chk("clrpri_we", 64'(mem_we), 64'd0);
    chk("clrpri_count", 64'(count), 64'd0);
    chk("clrpri_done", 64'(done), 64'd0);
    chk("clrpri_ready", 64'(in_ready), 64'd1);

    set_fields(tbl[2]);
    in_valid = 1'b1;
    step();
    chk("rej_err", 64'(err), 64'd1);
    chk("rej_count", 64'(count), 64'd0);
    set_fields(tbl[3]);
    step();
    in_valid = 1'b0;
    chk("pre_rst_we", 64'(mem_we), 64'd1);
    chk("pre_rst_wd", 64'(mem_wd), 64'h8537FFFF);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", 64'(mem_we), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rel_ready", 64'(in_ready), 64'd1);
    chk("rel_count", 64'(count), 64'd0);
    chk("rel_err", 64'(err), 64'd0);
    chk("rel_we", 64'(mem_we), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
